// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_pkg
//  Description : Shared definitions for the UART transmit controller: FSM
//                state encoding, line-select constants used by both the
//                controller and the line multiplexer, and the state-to-select
//                decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    // Transmit FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Line multiplexer select codes
    localparam logic [1:0] MUX_START = 2'b00;  // start bit, line low
    localparam logic [1:0] MUX_STOP  = 2'b01;  // stop bit / idle, line high
    localparam logic [1:0] MUX_DATA  = 2'b10;  // serializer output
    localparam logic [1:0] MUX_PAR   = 2'b11;  // parity unit output

    // Line select for a given state; idle shares the stop code so the line rests high
    function automatic logic [1:0] mux_sel_for(input tx_state_e st);
        logic [1:0] sel;
        sel = MUX_STOP;
        case (st)
            ST_START:  sel = MUX_START;
            ST_DATA:   sel = MUX_DATA;
            ST_PARITY: sel = MUX_PAR;
            default:   sel = MUX_STOP;
        endcase
        return sel;
    endfunction

endpackage : uart_tx_pkg
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : UART transmit controller. Sequences START, DATA_WIDTH data
//                bits, optional PARITY and STOP, one bit per CLK cycle, and
//                drives the serializer, parity unit and line multiplexer.
//                Build option UART_TX_PARITY_EN: when defined, the PARITY
//                state and PAR_EN/PAR_TYP latching are present; otherwise
//                frames carry no parity bit and par_load/par_typ_q are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       ser_load,
    output logic       ser_shift,
    output logic       par_load,
    output logic       par_typ_q,
    output logic [1:0] mux_sel,
    output logic       busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    tx_state_e        state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [1:0]       mux_sel_q,   mux_sel_d;
    logic             busy_q,      busy_d;
    logic             ser_shift_q, ser_shift_d;
    logic             accept;

`ifdef UART_TX_PARITY_EN
    logic             par_en_q,      par_en_d;
    logic             par_typ_lat_q, par_typ_lat_d;
`else
    logic             unused_par_inputs;
    assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

    // A request is taken only in IDLE or STOP; gated by reset so no load strobe escapes while held in reset
    always_comb begin
        accept = RST && Data_Valid && ((state_q == ST_IDLE) || (state_q == ST_STOP));
    end

    // Next-state, bit-counter and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef UART_TX_PARITY_EN
        par_en_d      = par_en_q;
        par_typ_lat_d = par_typ_lat_q;
        if (accept) begin
            par_en_d      = PAR_EN;
            par_typ_lat_d = PAR_TYP;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                cnt_d   = '0;
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
`ifdef UART_TX_PARITY_EN
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                    state_d = ST_STOP;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                state_d = accept ? ST_START : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moore outputs are decoded from the next state so they are glitch-free flops
        mux_sel_d   = mux_sel_for(state_d);
        busy_d      = (state_d != ST_IDLE);
        ser_shift_d = (state_d == ST_DATA);
    end

    // State, counter and output registers; reset returns the line high at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            mux_sel_q     <= MUX_STOP;
            busy_q        <= 1'b0;
            ser_shift_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q      <= 1'b0;
            par_typ_lat_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mux_sel_q     <= mux_sel_d;
            busy_q        <= busy_d;
            ser_shift_q   <= ser_shift_d;
`ifdef UART_TX_PARITY_EN
            par_en_q      <= par_en_d;
            par_typ_lat_q <= par_typ_lat_d;
`endif
        end
    end

    // Load strobes fire in the accept cycle so the serializer and parity unit
    // capture on the same edge that moves the FSM to START. The parity type is
    // passed through during that cycle so the parity unit sees the new value
    // at its capture edge, and holds the latched value for the rest of the frame.
    always_comb begin
        ser_load  = accept;
`ifdef UART_TX_PARITY_EN
        par_load  = accept;
        par_typ_q = accept ? PAR_TYP : par_typ_lat_q;
`else
        par_load  = 1'b0;
        par_typ_q = 1'b0;
`endif
    end

    assign mux_sel   = mux_sel_q;
    assign busy      = busy_q;
    assign ser_shift = ser_shift_q;

endmodule : uart_tx_ctrl
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Self-checking bench for uart_tx_ctrl. Each request pushes
//                its expected frame to a scoreboard; a monitor rebuilds
//                frames from mux_sel/busy/ser_shift and compares on STOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       ser_load;
    logic       ser_shift;
    logic       par_load;
    logic       par_typ_q;
    logic [1:0] mux_sel;
    logic       busy;

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_load   (ser_load),
        .ser_shift  (ser_shift),
        .par_load   (par_load),
        .par_typ_q  (par_typ_q),
        .mux_sel    (mux_sel),
        .busy       (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int len;
        bit par;
        bit pload;
        bit typ;
        bit b2b;
    } frame_t;

    frame_t sb[$];
    int     n_checks   = 0;
    int     n_errors   = 0;
    int     n_acc_exp  = 0;
    int     n_ser_load = 0;
    int     n_stray    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input bit pe, input bit pt, input bit b2b);
        frame_t f;
        f.par   = PAR_BUILD && pe;
        f.len   = DW + 2 + (f.par ? 1 : 0);
        f.pload = PAR_BUILD;
        f.typ   = PAR_BUILD && pt;
        f.b2b   = b2b;
        sb.push_back(f);
        n_acc_exp++;
    endtask

    task automatic drive(input bit dv, input bit pe, input bit pt);
        @(posedge CLK);
        #1;
        Data_Valid = dv;
        PAR_EN     = pe;
        PAR_TYP    = pt;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy !== 1'b0 && n < bound);
        check_val("idle_within_bound", busy, 0);
    endtask

    // ---------------- frame monitor ----------------
    bit     in_frame = 0;
    int     m_len, m_data, m_shift, m_par, m_phase;
    bit     m_order;
    bit     p_ser_load, p_par_load, p_par_typ, p_busy;
    bit     s_ser_load, s_par_load, s_par_typ, s_busy, s_typ_mid;
    frame_t mf;

    always @(negedge CLK) begin
        if (!RST) begin
            in_frame   = 0;
            p_ser_load = 0;
            p_par_load = 0;
            p_par_typ  = 0;
            p_busy     = 0;
        end else begin
            if (ser_load === 1'b1) n_ser_load++;
            if (mux_sel === 2'b00 && busy === 1'b1) begin
                if (in_frame) check_val("frame_unterminated", 1, 0);
                in_frame   = 1;
                m_len      = 1;
                m_data     = 0;
                m_par      = 0;
                m_phase    = 0;
                m_order    = 1;
                m_shift    = (ser_shift === 1'b1) ? 1 : 0;
                s_ser_load = p_ser_load;
                s_par_load = p_par_load;
                s_par_typ  = p_par_typ;
                s_busy     = p_busy;
                s_typ_mid  = par_typ_q;
            end else if (in_frame) begin
                m_len++;
                if (ser_shift === 1'b1) m_shift++;
                if (mux_sel === 2'b10) begin
                    if (m_phase == 2) m_order = 0;
                    m_phase = 1;
                    m_data++;
                end else if (mux_sel === 2'b11) begin
                    if (m_phase == 0) m_order = 0;
                    m_phase = 2;
                    m_par++;
                end else begin
                    if (m_phase == 0 || busy !== 1'b1 || mux_sel !== 2'b01) m_order = 0;
                    in_frame = 0;
                    if (sb.size() == 0) begin
                        check_val("unexpected_frame", 1, 0);
                    end else begin
                        mf = sb.pop_front();
                        check_val("frame_len",        m_len,      mf.len);
                        check_val("data_cycles",      m_data,     DW);
                        check_val("shift_cycles",     m_shift,    DW);
                        check_val("parity_cycles",    m_par,      mf.par ? 1 : 0);
                        check_val("mux_order",        m_order,    1);
                        check_val("ser_load_accept",  s_ser_load, 1);
                        check_val("par_load_accept",  s_par_load, mf.pload);
                        check_val("par_typ_accept",   s_par_typ,  mf.typ);
                        check_val("par_typ_in_frame", s_typ_mid,  mf.typ);
                        check_val("back_to_back",     s_busy,     mf.b2b);
                    end
                end
            end else if (mux_sel !== 2'b01 || busy !== 1'b0 || ser_shift !== 1'b0) begin
                n_stray++;
            end
            p_ser_load = (ser_load === 1'b1);
            p_par_load = (par_load === 1'b1);
            p_par_typ  = (par_typ_q === 1'b1);
            p_busy     = (busy === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #12;
        check_val("rst_busy",      busy,      0);
        check_val("rst_mux_sel",   mux_sel,   1);
        check_val("rst_ser_load",  ser_load,  0);
        check_val("rst_ser_shift", ser_shift, 0);
        check_val("rst_par_load",  par_load,  0);
        check_val("rst_par_typ_q", par_typ_q, 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);

        // single frame, no parity
        push_frame(0, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        wait_idle(20);

        // parity enabled, odd
        push_frame(1, 1, 0);
        drive(1, 1, 1);
        drive(0, 1, 1);
        wait_idle(20);

        // parity enabled, even
        push_frame(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 0, 0);
        wait_idle(20);

        // Data_Valid held: three frames back to back (no parity, 10-cycle frames)
        push_frame(0, 0, 0);
        push_frame(0, 0, 1);
        push_frame(0, 0, 1);
        for (int i = 0; i < 2 * (DW + 2) + 1; i++) drive(1, 0, 0);
        drive(0, 0, 0);
        wait_idle(20);

        // requests in DATA cycle 3 and in PARITY are ignored
        push_frame(1, 0, 0);
        drive(1, 1, 0);                         // accept
        drive(0, 1, 0);                         // START
        drive(0, 1, 0);                         // DATA 1
        drive(0, 1, 0);                         // DATA 2
        drive(1, 1, 0);                         // DATA 3
        for (int i = 0; i < 5; i++) drive(0, 1, 0);   // DATA 4..8
`ifdef UART_TX_PARITY_EN
        drive(1, 1, 0);                         // PARITY
`else
        drive(0, 1, 0);                         // STOP
`endif
        drive(0, 0, 0);
        wait_idle(20);
        drive(0, 0, 0);
        check_val("no_queued_frame", busy, 0);

        // reset during DATA cycle 5, then immediate new request
        n_acc_exp++;                            // aborted frame still loads once
        drive(1, 0, 0);                         // accept
        for (int i = 0; i < 6; i++) drive(0, 0, 0);   // START, DATA 1..5
        #2 RST = 1'b0;
        #1;
        check_val("abort_mux_sel",   mux_sel,   1);
        check_val("abort_busy",      busy,      0);
        check_val("abort_ser_shift", ser_shift, 0);
        Data_Valid = 1'b1;
        #1;
        check_val("abort_ser_load",  ser_load,  0);
        check_val("abort_par_load",  par_load,  0);
        check_val("abort_par_typ_q", par_typ_q, 0);
        push_frame(1, 1, 0);
        @(posedge CLK);
        #1;
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b1;
        #1 RST = 1'b1;                          // first edge after release accepts
        drive(0, 1, 1);
        wait_idle(20);

        // PAR_EN/PAR_TYP changed mid-frame do not alter the frame
        push_frame(0, 1, 0);
        drive(1, 0, 1);
        drive(0, 0, 1);
        drive(0, 1, 0);
        drive(0, 1, 0);
        wait_idle(20);
        push_frame(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 1, 0);
        drive(0, 0, 1);
        wait_idle(20);

        drive(0, 0, 0);
        drive(0, 0, 0);
        check_val("scoreboard_empty", sb.size(), 0);
        check_val("ser_load_count",   n_ser_load, n_acc_exp);
        check_val("idle_stray",       n_stray,    0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so a stuck run still ends with a summary
    initial begin
        #200000;
        check_val("global_timeout", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_tx_ctrl
`default_nettype wire

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning serial data bits per frame (range 5..8).
REQ-002 SHALL have port CLK  input  1  bit-rate clock; one serial bit per CLK cycle.
REQ-003 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Data_Valid  input  1  request to send the word currently on the datapath.
REQ-005 SHALL have port PAR_EN  input  1  parity bit appended when 1.
REQ-006 SHALL have port PAR_TYP  input  1  0 even, 1 odd; forwarded to the parity unit.
REQ-007 SHALL have port ser_load  output  1  serializer parallel-load strobe.
REQ-008 SHALL have port ser_shift  output  1  serializer shift enable.
REQ-009 SHALL have port par_load  output  1  parity-unit capture strobe (drives its data_valid).
REQ-010 SHALL have port par_typ_q  output  1  latched PAR_TYP, to the parity unit.
REQ-011 SHALL have port mux_sel  output  2  line select: 00 start(0), 01 stop(1), 10 serial data, 11 parity bit.
REQ-012 SHALL have port busy  output  1  frame in progress.

Function
REQ-013 SHALL implement a Moore FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL accept a request when Data_Valid=1 in IDLE or STOP; Data_Valid in START/DATA/PARITY SHALL be ignored, with no queuing.
REQ-015 SHALL, in the accept cycle, assert ser_load and par_load for exactly one cycle, latch PAR_EN and PAR_TYP, and go to START next cycle.
REQ-016 SHALL hold START for 1 cycle, then DATA for exactly DATA_WIDTH cycles with ser_shift=1 in every DATA cycle.
REQ-017 SHALL go from DATA to PARITY (1 cycle) when latched PAR_EN=1, otherwise directly to STOP.
REQ-018 SHALL hold STOP 1 cycle, then go to START on accept (back-to-back, no idle gap) or to IDLE otherwise.
REQ-019 SHALL count DATA cycles with a counter of ceil(log2(DATA_WIDTH)) bits, cleared on entry to DATA; the final DATA cycle is count==DATA_WIDTH-1.
REQ-020 SHALL decode mux_sel: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01; the line idles high.
REQ-021 SHALL drive busy=1 in START, DATA, PARITY and STOP, and 0 in IDLE.
REQ-022 SHALL give a frame length of DATA_WIDTH+2 cycles, plus 1 when parity is enabled.
REQ-023 SHALL ignore changes to PAR_EN and PAR_TYP mid-frame; the latched values govern the frame.

Reset
REQ-024 SHALL, on RST low, immediately enter IDLE: busy=0, mux_sel=01, ser_load=0, ser_shift=0, par_load=0, par_typ_q=0, counter=0.
REQ-025 SHALL abort any frame in progress on reset; the line returns high the same instant, with no partial stop bit.
REQ-026 SHALL accept Data_Valid on the first CLK edge after RST deasserts.

Configuration
REQ-027 SHALL support macro UART_TX_PARITY_EN: when defined, the PARITY state and PAR_EN/PAR_TYP latching are present as specified.
REQ-028 SHALL, without UART_TX_PARITY_EN, omit the PARITY state, tie par_load and par_typ_q to 0, ignore PAR_EN, and never emit mux_sel=11; frame length is DATA_WIDTH+2.

Structure
REQ-029 SHALL take the state encoding and the four mux_sel constants (MUX_START, MUX_STOP, MUX_DATA, MUX_PAR) from shared package uart_tx_pkg, which the mux also uses.
REQ-030 SHALL be a single module with no sub-module; the FSM and bit counter are inline.

Verification
REQ-031 SHALL verify: DATA_WIDTH=8, PAR_EN=0, Data_Valid pulse in IDLE -> busy high 10 cycles; mux_sel 00, then 10 x8, then 01; ser_shift high exactly 8 cycles.
REQ-032 SHALL verify: PAR_EN=1, PAR_TYP=1, one request -> 11-cycle frame; mux_sel=11 in cycle 10; par_load and par_typ_q=1 in the accept cycle.
REQ-033 SHALL verify: Data_Valid held high continuously -> consecutive frames, STOP followed directly by START, ser_load once per frame in each STOP cycle.
REQ-034 SHALL verify: Data_Valid pulses in DATA cycle 3 and in PARITY -> ignored; busy falls after the current frame.
REQ-035 SHALL verify: RST low in DATA cycle 5 -> mux_sel=01 and busy=0 asynchronously; a new request after release gives a clean full frame.
REQ-036 SHALL verify: PAR_EN toggled mid-frame -> frame length unchanged from the value latched at accept.
